// File: rtl/itch_mold_framer_if.sv
// Byte-stream in / framed ITCH message stream out; the framer takes the slave side.
interface itch_mold_framer_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        msg_valid;
    logic [7:0]  msg_byte;
    logic        msg_first;
    logic        msg_last;
    logic        msg_abort;
    logic [7:0]  msg_type;
    logic [63:0] msg_seq;

    modport master (
        output in_valid, in_byte, in_last,
        input  msg_valid, msg_byte, msg_first, msg_last, msg_abort, msg_type, msg_seq
    );
    modport slave (
        input  in_valid, in_byte, in_last,
        output msg_valid, msg_byte, msg_first, msg_last, msg_abort, msg_type, msg_seq
    );
endinterface

// File: rtl/itch_mold_framer.sv
// Skips L2-L4 headers, parses MoldUDP64 and splits payload into framed ITCH messages.
// One-cycle registered latency; no backpressure, in_valid gaps simply stall the parser.
module itch_mold_framer #(
    parameter int PAYLOAD_OFFSET = 46,
    parameter int MAX_MSG_LEN    = 64,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    itch_mold_framer_if.slave  bus,
    output logic               hdr_valid,
    output logic [79:0]        session,
    output logic [63:0]        seq_num,
    output logic [15:0]        msg_count,
    output logic               heartbeat,
    output logic               end_session,
    output logic               seq_gap,
    output logic               err_trunc,
    output logic               err_len,
    output logic [CNT_W-1:0]   pkt_cnt
);
    typedef enum logic [2:0] {SKIP, HDR, LEN_HI, LEN_LO, BODY, TAIL, DRAIN} state_t;

    localparam logic [15:0]      OFF_LAST = 16'(PAYLOAD_OFFSET - 1);
    localparam logic [15:0]      MAX_LEN  = 16'(MAX_MSG_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t        state;
    logic [15:0]   cnt;
    logic [151:0]  hdr_sr;
    logic [7:0]    len_hi;
    logic [15:0]   msg_len;
    logic [15:0]   remaining;
    logic [63:0]   cur_seq;
    logic [63:0]   expected;
    logic          locked;

    logic [159:0]  hdr_full;
    logic [15:0]   new_len;
    logic          hdr_done;
    logic          body_end;
    logic          trunc_now;

    always_comb begin
        hdr_full = {hdr_sr, bus.in_byte};
        new_len  = {len_hi, bus.in_byte};
        hdr_done = (state == HDR) && (cnt == 16'd19);
        body_end = (cnt == msg_len - 16'd1);
        trunc_now = 1'b0;
        case (state)
            SKIP, LEN_HI, LEN_LO: trunc_now = 1'b1;
            // A header-only frame is legal only for heartbeat / end-of-session.
            HDR:  trunc_now = !hdr_done || (hdr_full[15:0] != 16'h0000 && hdr_full[15:0] != 16'hFFFF);
            BODY: trunc_now = !body_end;
            default: trunc_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SKIP;
            cnt           <= '0;
            hdr_sr        <= '0;
            len_hi        <= '0;
            msg_len       <= '0;
            remaining     <= '0;
            cur_seq       <= '0;
            expected      <= '0;
            locked        <= 1'b0;
            bus.msg_valid <= 1'b0;
            bus.msg_byte  <= '0;
            bus.msg_first <= 1'b0;
            bus.msg_last  <= 1'b0;
            bus.msg_abort <= 1'b0;
            bus.msg_type  <= '0;
            bus.msg_seq   <= '0;
            hdr_valid     <= 1'b0;
            session       <= '0;
            seq_num       <= '0;
            msg_count     <= '0;
            heartbeat     <= 1'b0;
            end_session   <= 1'b0;
            seq_gap       <= 1'b0;
            err_trunc     <= 1'b0;
            err_len       <= 1'b0;
            pkt_cnt       <= '0;
        end else begin
            bus.msg_valid <= 1'b0;
            bus.msg_first <= 1'b0;
            bus.msg_last  <= 1'b0;
            bus.msg_abort <= 1'b0;
            hdr_valid     <= 1'b0;
            heartbeat     <= 1'b0;
            end_session   <= 1'b0;
            seq_gap       <= 1'b0;
            err_trunc     <= 1'b0;
            err_len       <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    SKIP: begin
                        if (cnt == OFF_LAST) begin
                            state <= HDR;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    HDR: begin
                        hdr_sr <= hdr_full[151:0];
                        if (hdr_done) begin
                            cnt       <= '0;
                            hdr_valid <= 1'b1;
                            session   <= hdr_full[159:80];
                            seq_num   <= hdr_full[79:16];
                            msg_count <= hdr_full[15:0];
                            seq_gap   <= locked && (hdr_full[79:16] != expected);
                            // end_session unlocks; heartbeat (count 0) locks expected to seq itself.
                            locked    <= (hdr_full[15:0] != 16'hFFFF);
                            expected  <= hdr_full[79:16] + {48'd0, hdr_full[15:0]};
                            if (hdr_full[15:0] == 16'h0000) begin
                                heartbeat <= 1'b1;
                                state     <= DRAIN;
                            end else if (hdr_full[15:0] == 16'hFFFF) begin
                                end_session <= 1'b1;
                                state       <= DRAIN;
                            end else begin
                                remaining <= hdr_full[15:0];
                                cur_seq   <= hdr_full[79:16];
                                state     <= LEN_HI;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    LEN_HI: begin
                        len_hi <= bus.in_byte;
                        state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        if (new_len == 16'd0 || new_len > MAX_LEN) begin
                            err_len <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            msg_len <= new_len;
                            cnt     <= '0;
                            state   <= BODY;
                        end
                    end
                    BODY: begin
                        bus.msg_valid <= 1'b1;
                        bus.msg_byte  <= bus.in_byte;
                        bus.msg_first <= (cnt == 16'd0);
                        bus.msg_last  <= body_end;
                        bus.msg_seq   <= cur_seq;
                        if (cnt == 16'd0)
                            bus.msg_type <= bus.in_byte;
                        if (body_end) begin
                            cur_seq   <= cur_seq + 64'd1;
                            remaining <= remaining - 16'd1;
                            cnt       <= '0;
                            state     <= (remaining == 16'd1) ? TAIL : LEN_HI;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    TAIL: begin
                        err_len <= 1'b1;
                        state   <= DRAIN;
                    end
                    default: ;
                endcase
                if (bus.in_last) begin
                    state   <= SKIP;
                    cnt     <= '0;
                    pkt_cnt <= pkt_cnt + CNT_ONE;
                    if (trunc_now) begin
                        err_trunc <= 1'b1;
                        err_len   <= 1'b0;
                    end
                    if (state == BODY && !body_end) begin
                        bus.msg_last  <= 1'b1;
                        bus.msg_abort <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_itch_mold_framer.sv
// Directed scenarios for itch_mold_framer with a message-byte scoreboard and pulse counters.
module tb_itch_mold_framer;
    logic        clk = 1'b0;
    logic        reset;
    logic        hdr_valid, heartbeat, end_session, seq_gap, err_trunc, err_len;
    logic [79:0] session;
    logic [63:0] seq_num;
    logic [15:0] msg_count;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    itch_mold_framer_if bus ();

    itch_mold_framer #(.PAYLOAD_OFFSET(46), .MAX_MSG_LEN(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .hdr_valid(hdr_valid), .session(session), .seq_num(seq_num), .msg_count(msg_count),
        .heartbeat(heartbeat), .end_session(end_session), .seq_gap(seq_gap),
        .err_trunc(err_trunc), .err_len(err_len), .pkt_cnt(pkt_cnt)
    );

    typedef struct packed {
        logic [7:0]  b;
        logic        first;
        logic        last;
        logic        abort;
        logic [7:0]  typ;
        logic [63:0] seq;
    } exp_t;

    localparam logic [79:0] SESS = 80'h53_45_53_53_49_4F_4E_30_30_31;

    exp_t        sbq[$];
    logic [7:0]  frm[$];
    int          tests = 0;
    int          fails = 0;
    int          ev[6];
    int          base[6];
    bit          gaps = 1'b0;

    task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    // Samples outputs produced by the previous rising edge.
    task automatic observe();
        exp_t e;
        exp_t got;
        if (bus.msg_valid) begin
            tests++;
            assert (sbq.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_msg_byte: got %0h want none", bus.msg_byte);
            end
            if (sbq.size() != 0) begin
                e   = sbq.pop_front();
                got = '{bus.msg_byte, bus.msg_first, bus.msg_last, bus.msg_abort, bus.msg_type, bus.msg_seq};
                tests++;
                assert (got === e) else begin
                    fails++;
                    $error("FAIL msg_byte_stream: got %0h want %0h", got, e);
                end
            end
        end
        if (err_len || err_trunc) begin
            tests++;
            assert (!(err_len && err_trunc)) else begin
                fails++;
                $error("FAIL err_exclusive: got len=%0b trunc=%0b want not both", err_len, err_trunc);
            end
        end
        if (hdr_valid)   ev[0]++;
        if (heartbeat)   ev[1]++;
        if (end_session) ev[2]++;
        if (seq_gap)     ev[3]++;
        if (err_trunc)   ev[4]++;
        if (err_len)     ev[5]++;
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic l);
        @(negedge clk);
        observe();
        bus.in_valid = v;
        bus.in_byte  = b;
        bus.in_last  = l;
    endtask

    task automatic build_hdr(input logic [63:0] seq, input logic [15:0] cnt);
        for (int i = 0; i < 46; i++) frm.push_back(8'(i + 8'h80));
        for (int i = 0; i < 10; i++) frm.push_back(SESS[79-8*i -: 8]);
        for (int i = 0; i < 8; i++)  frm.push_back(seq[63-8*i -: 8]);
        frm.push_back(cnt[15:8]);
        frm.push_back(cnt[7:0]);
    endtask

    // Appends a length-prefixed message with nb body bytes; cut marks the frame ending inside it.
    task automatic build_msg(input logic [15:0] len, input logic [7:0] typ, input logic [63:0] seq,
                             input int nb, input bit cut);
        exp_t e;
        logic [7:0] b;
        frm.push_back(len[15:8]);
        frm.push_back(len[7:0]);
        for (int k = 0; k < nb; k++) begin
            b = (k == 0) ? typ : 8'(typ + 8'(k));
            frm.push_back(b);
            if (len != 16'd0 && len <= 16'd64) begin
                e.b     = b;
                e.first = (k == 0);
                e.last  = (k == int'(len) - 1) || (cut && k == nb - 1);
                e.abort = cut && (k == nb - 1);
                e.typ   = typ;
                e.seq   = seq;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < frm.size(); i++) begin
            if (gaps && $urandom_range(1, 0) == 1) step(1'b0, 8'h00, 1'b0);
            step(1'b1, frm[i], i == frm.size() - 1);
        end
        frm.delete();
        repeat (3) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_ev(input string tag, input int h, input int hb, input int es,
                            input int gp, input int tr, input int ln);
        check({tag, "_hdr_valid"},   80'(ev[0] - base[0]), 80'(h));
        check({tag, "_heartbeat"},   80'(ev[1] - base[1]), 80'(hb));
        check({tag, "_end_session"}, 80'(ev[2] - base[2]), 80'(es));
        check({tag, "_seq_gap"},     80'(ev[3] - base[3]), 80'(gp));
        check({tag, "_err_trunc"},   80'(ev[4] - base[4]), 80'(tr));
        check({tag, "_err_len"},     80'(ev[5] - base[5]), 80'(ln));
        check({tag, "_sb_empty"},    80'(sbq.size()), 80'd0);
        for (int i = 0; i < 6; i++) base[i] = ev[i];
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_session"}, session, 80'd0);
        check({tag, "_seq_num"}, 80'(seq_num), 80'd0);
        check({tag, "_pkt_cnt"}, 80'(pkt_cnt), 80'd0);
        check({tag, "_msg_seq"}, 80'(bus.msg_seq), 80'd0);
        check({tag, "_flags"}, 80'({bus.msg_valid, bus.msg_first, bus.msg_last, bus.msg_abort,
                                    bus.msg_byte, bus.msg_type, hdr_valid, heartbeat, end_session,
                                    seq_gap, err_trunc, err_len, msg_count}), 80'd0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin ev[i] = 0; base[i] = 0; end
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Basic frame: two messages, sequence locks at 102.
        build_hdr(64'd100, 16'd2);
        build_msg(16'd12, 8'h53, 64'd100, 12, 1'b0);
        build_msg(16'd36, 8'h41, 64'd101, 36, 1'b0);
        send_frame();
        check_ev("f1", 1, 0, 0, 0, 0, 0);
        check("f1_session", session, SESS);
        check("f1_seq_num", 80'(seq_num), 80'd100);
        check("f1_msg_count", 80'(msg_count), 80'd2);
        check("f1_pkt_cnt", 80'(pkt_cnt), 80'd1);

        build_hdr(64'd105, 16'd2);
        build_msg(16'd8, 8'h45, 64'd105, 8, 1'b0);
        build_msg(16'd8, 8'h46, 64'd106, 8, 1'b0);
        send_frame();
        check_ev("gap", 1, 0, 0, 1, 0, 0);

        build_hdr(64'd107, 16'd1);
        build_msg(16'd10, 8'h44, 64'd107, 10, 1'b0);
        send_frame();
        check_ev("nogap", 1, 0, 0, 0, 0, 0);

        build_hdr(64'd108, 16'd0);
        send_frame();
        check_ev("hb", 1, 1, 0, 0, 0, 0);

        build_hdr(64'd108, 16'hFFFF);
        send_frame();
        check_ev("eos", 1, 0, 1, 0, 0, 0);
        check("eos_msg_count", 80'(msg_count), 80'hFFFF);

        build_hdr(64'd5000, 16'd1);
        build_msg(16'd4, 8'h50, 64'd5000, 4, 1'b0);
        send_frame();
        check_ev("unlocked", 1, 0, 0, 0, 0, 0);

        build_hdr(64'd5001, 16'd1);
        build_msg(16'd12, 8'h53, 64'd5001, 5, 1'b1);
        send_frame();
        check_ev("trunc", 1, 0, 0, 0, 1, 0);
        check("trunc_pkt_cnt", 80'(pkt_cnt), 80'd7);

        build_hdr(64'd5002, 16'd2);
        build_msg(16'd0, 8'h58, 64'd0, 4, 1'b0);
        send_frame();
        check_ev("len0", 1, 0, 0, 0, 0, 1);

        build_hdr(64'd5004, 16'd1);
        build_msg(16'd65, 8'h58, 64'd0, 10, 1'b0);
        send_frame();
        check_ev("len65", 1, 0, 0, 0, 0, 1);

        build_hdr(64'd5005, 16'd1);
        build_msg(16'd4, 8'h45, 64'd5005, 4, 1'b0);
        frm.push_back(8'h11); frm.push_back(8'h22); frm.push_back(8'h33);
        send_frame();
        check_ev("extra", 1, 0, 0, 0, 0, 1);

        gaps = 1'b1;
        build_hdr(64'd5006, 16'd2);
        build_msg(16'd12, 8'h53, 64'd5006, 12, 1'b0);
        build_msg(16'd36, 8'h41, 64'd5007, 36, 1'b0);
        send_frame();
        gaps = 1'b0;
        check_ev("gaps", 1, 0, 0, 0, 0, 0);
        check("gaps_pkt_cnt", 80'(pkt_cnt), 80'd11);

        // Reset mid-body: six bytes of a 20-byte message escape, then everything clears.
        build_hdr(64'd5008, 16'd1);
        build_msg(16'd20, 8'h51, 64'd5008, 6, 1'b0);
        for (int i = 0; i < frm.size(); i++) step(1'b1, frm[i], 1'b0);
        frm.delete();
        step(1'b0, 8'h00, 1'b0);
        check_ev("pre_rst", 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_rst");
        reset = 1'b0;

        build_hdr(64'd42, 16'd1);
        build_msg(16'd3, 8'h52, 64'd42, 3, 1'b0);
        send_frame();
        check_ev("post_rst", 1, 0, 0, 0, 0, 0);
        check("post_rst_pkt_cnt", 80'(pkt_cnt), 80'd1);
        check("post_rst_seq_num", 80'(seq_num), 80'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/itch_mold_framer.md
Name: itch_mold_framer

Overview:
- Parametrised successor to the fixed-offset ITCH packet decoder.
- Takes a byte stream from the packet source and skips the link/IP/UDP headers, which are a configurable length.
- Parses the MoldUDP64 header, then splits the payload into individual length-prefixed ITCH messages, emitted as a framed byte stream.
- Adds heartbeat/end-of-session detection, sequence-gap tracking, and truncation/length error reporting; it feeds the per-message-type decoders.

Parameters:
PAYLOAD_OFFSET, 46, byte index of first MoldUDP64 byte within the frame (42 for untagged Ethernet)
MAX_MSG_LEN, 64, largest legal ITCH message length in bytes; longer is an error
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  in_byte is valid this cycle
in_byte  in  8  frame byte, network order
in_last  in  1  qualifies last byte of frame (with in_valid)
msg_valid  out  1  msg_byte valid
msg_byte  out  8  message byte (type byte first)
msg_first  out  1  first byte of message
msg_last  out  1  last byte of message
msg_abort  out  1  with msg_last: message was truncated, discard
msg_type  out  8  type byte of current message, held from msg_first to msg_last
msg_seq  out  64  MoldUDP64 sequence number of current message
hdr_valid  out  1  one-cycle pulse: session/seq_num/msg_count updated
session  out  80  session field of last header
seq_num  out  64  sequence field of last header
msg_count  out  16  message-count field of last header
heartbeat  out  1  pulse: msg_count==0
end_session  out  1  pulse: msg_count==16'hFFFF
seq_gap  out  1  pulse: seq_num != expected sequence
err_trunc  out  1  pulse: in_last before header or message complete
err_len  out  1  pulse: zero/oversize length, or extra bytes after final message
pkt_cnt  out  CNT_W  frames seen (in_last count), wraps

Behaviour:
- Reset: all outputs 0, FSM=SKIP, byte counter 0, expected sequence unlocked.
- Reset has priority over all inputs and aborts any frame in progress without pulses.
- in_valid=0: no state, counter or output change; msg_valid=0 that cycle.
- All outputs are registered. Message bytes appear 1 cycle after the accepted input byte. Pulses are 1 cycle wide.
- FSM states:
  - SKIP: count bytes until PAYLOAD_OFFSET bytes have been consumed, then go to HDR.
  - HDR: 20 bytes, big-endian: session[79:0] (10 bytes), seq_num (8), msg_count (2).
    - On the 20th byte: hdr_valid=1.
    - msg_count 0 -> heartbeat; 16'hFFFF -> end_session; in both cases go to DRAIN.
    - Otherwise remaining=msg_count, cur_seq=seq_num, go to LEN_HI.
  - LEN_HI / LEN_LO: 16-bit big-endian message length L.
    - L==0 or L>MAX_MSG_LEN -> err_len, go to DRAIN.
    - Otherwise go to BODY.
  - BODY: forward L bytes. msg_first on byte 1 (msg_type latched), msg_last on byte L, msg_seq=cur_seq.
    - After byte L: cur_seq+1, remaining-1.
    - If remaining becomes 0 go to TAIL, else go to LEN_HI.
  - TAIL: if in_last arrived with the final body byte, go to SKIP. Any further byte -> err_len (once), go to DRAIN.
  - DRAIN: discard bytes until in_last.
- in_last in any state returns the FSM to SKIP, byte counter 0, and increments pkt_cnt (wrapping).
  - in SKIP, HDR, LEN_HI or LEN_LO: err_trunc; LEN_HI qualifies only if remaining>0 was expected there.
  - in BODY on a byte other than byte L: that byte is emitted with msg_last=1, msg_abort=1, and err_trunc is raised.
  - in BODY on byte L: normal, no error.
  - in TAIL or DRAIN: normal.
- Sequence tracking:
  - The first hdr_valid after reset locks expected=seq_num+msg_count, with no seq_gap.
  - Later headers: seq_gap if seq_num!=expected, then expected=seq_num+count.
  - A heartbeat sets expected=seq_num (count 0) and still checks for a gap.
  - end_session unlocks expected.
  - 64-bit arithmetic, wraps.
- Simultaneous events:
  - err_len and err_trunc never pulse together; err_trunc wins.
  - hdr_valid with heartbeat/seq_gap pulse in the same cycle.

Test Plan:
- PAYLOAD_OFFSET=46; header seq=100, count=2; messages L=12 'S' and L=36 'A'; in_last on final byte -> hdr_valid, msg_seq 100 then 101, msg_first/last framing 12 and 36 bytes, no errors, pkt_cnt=1.
- Second frame seq=105 after the frame above (expected 102) -> seq_gap pulse; third frame seq=107 with count 1 -> no gap.
- Header count=0 -> heartbeat pulse, no msg_valid; count=16'hFFFF -> end_session; next frame with arbitrary seq -> no seq_gap.
- in_last on byte 5 of a 12-byte message -> 5 bytes emitted, 5th with msg_last=1 and msg_abort=1, err_trunc pulse, FSM back in SKIP.
- Length 0 or MAX_MSG_LEN+1 -> err_len, remaining bytes dropped; 3 extra bytes after final message -> single err_len.
- in_valid toggled 50% randomly during the first scenario -> identical output byte sequence; reset asserted mid-BODY -> all outputs 0, and the next frame parses cleanly without seq_gap.
